// File: rtl/mouse_click_ctrl.sv
// Pointer hit-testing for the start button and two game boards, plus a
// press/release qualifier that emits single-cycle click pulses.
module mouse_click_ctrl #(
    parameter int CELL_BITS   = 5,
    parameter int GRID_CELLS  = 10,
    parameter int COORD_W     = 4,
    parameter int PLAYER_XPOS = 96,
    parameter int ENEMY_XPOS  = 544,
    parameter int GRID_YPOS   = 192,
    parameter int SBTN_XPOS   = 448,
    parameter int SBTN_YPOS   = 40,
    parameter int SBTN_W      = 128,
    parameter int SBTN_H      = 64,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [11:0]          x_pos,
    input  logic [11:0]          y_pos,
    input  logic                 left,
    input  logic                 player_en,
    input  logic                 enemy_en,
    output logic [2*COORD_W-1:0] player_cor,
    output logic [2*COORD_W-1:0] enemy_cor,
    output logic                 start_click,
    output logic                 player_click,
    output logic                 enemy_click,
    output logic [2*COORD_W-1:0] click_cor,
    output logic                 busy
);
    localparam int CW      = 2 * COORD_W;
    localparam int GRID_PX = GRID_CELLS << CELL_BITS;
    localparam int CNT_W   = $clog2(HOLDOFF_CYC + 1);

    localparam logic [11:0] GRID_Y0 = 12'(GRID_YPOS);
    localparam logic [11:0] GRID_Y1 = 12'(GRID_YPOS + GRID_PX);
    localparam logic [11:0] BTN_X0  = 12'(SBTN_XPOS);
    localparam logic [11:0] BTN_X1  = 12'(SBTN_XPOS + SBTN_W);
    localparam logic [11:0] BTN_Y0  = 12'(SBTN_YPOS);
    localparam logic [11:0] BTN_Y1  = 12'(SBTN_YPOS + SBTN_H);

    typedef enum logic [1:0] {TGT_NONE, TGT_BTN, TGT_PLAYER, TGT_ENEMY} tgt_t;
    typedef enum logic [1:0] {IDLE, ARMED, CANCEL, HOLD} state_t;

    state_t            state_reg, state_next;
    tgt_t              cap_tgt_reg, cap_tgt_next;
    logic [CW-1:0]     cap_cell_reg, cap_cell_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              left_d_reg;
    logic              start_reg, start_next;
    logic              player_reg, player_next;
    logic              enemy_reg, enemy_next;
    logic [CW-1:0]     click_cor_reg, click_cor_next;
    logic [CW-1:0]     player_cor_reg, enemy_cor_reg;

    logic              in_rows, in_btn;
    logic [1:0]        in_board;
    logic [CW-1:0]     board_cell [2];
    logic [COORD_W-1:0] row_idx;
    tgt_t              cur_tgt;
    logic [CW-1:0]     cur_cell;
    logic              rise, fall, cap_en_lost;

    assign in_rows = (y_pos >= GRID_Y0) && (y_pos < GRID_Y1);
    assign row_idx = COORD_W'((y_pos - GRID_Y0) >> CELL_BITS);
    assign in_btn  = (x_pos >= BTN_X0) && (x_pos < BTN_X1) &&
                     (y_pos >= BTN_Y0) && (y_pos < BTN_Y1);

    // Board 0 is the player board, board 1 the enemy board.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_board
            localparam logic [11:0] X0 = (gi == 0) ? 12'(PLAYER_XPOS) : 12'(ENEMY_XPOS);
            localparam logic [11:0] X1 = X0 + 12'(GRID_PX);
            logic [COORD_W-1:0] col_idx;
            assign col_idx        = COORD_W'((x_pos - X0) >> CELL_BITS);
            assign in_board[gi]   = in_rows && (x_pos >= X0) && (x_pos < X1);
            assign board_cell[gi] = in_board[gi] ? {col_idx, row_idx} : '1;
        end
    endgenerate

    always_comb begin
        cur_tgt  = TGT_NONE;
        cur_cell = '1;
        if (in_btn) begin
            cur_tgt = TGT_BTN;
        end else if (in_board[0] && player_en) begin
            cur_tgt  = TGT_PLAYER;
            cur_cell = board_cell[0];
        end else if (in_board[1] && enemy_en) begin
            cur_tgt  = TGT_ENEMY;
            cur_cell = board_cell[1];
        end
    end

    assign rise        = left & ~left_d_reg;
    assign fall        = ~left & left_d_reg;
    assign cap_en_lost = ((cap_tgt_reg == TGT_PLAYER) && !player_en) ||
                         ((cap_tgt_reg == TGT_ENEMY)  && !enemy_en);

    always_comb begin
        state_next     = state_reg;
        cap_tgt_next   = cap_tgt_reg;
        cap_cell_next  = cap_cell_reg;
        cnt_next       = cnt_reg;
        start_next     = 1'b0;
        player_next    = 1'b0;
        enemy_next     = 1'b0;
        click_cor_next = click_cor_reg;
        case (state_reg)
            IDLE: begin
                if (rise && (cur_tgt != TGT_NONE)) begin
                    state_next    = ARMED;
                    cap_tgt_next  = cur_tgt;
                    cap_cell_next = cur_cell;
                end
            end
            ARMED: begin
                // Leaving the captured cell wins over a simultaneous release.
                if ((cur_tgt != cap_tgt_reg) || (cur_cell != cap_cell_reg) || cap_en_lost) begin
                    state_next = CANCEL;
                end else if (fall) begin
                    state_next = HOLD;
                    cnt_next   = CNT_W'(HOLDOFF_CYC);
                    case (cap_tgt_reg)
                        TGT_BTN:    start_next = 1'b1;
                        TGT_PLAYER: begin
                            player_next    = 1'b1;
                            click_cor_next = cap_cell_reg;
                        end
                        TGT_ENEMY:  begin
                            enemy_next     = 1'b1;
                            click_cor_next = cap_cell_reg;
                        end
                        default: ;
                    endcase
                end
            end
            CANCEL: begin
                if (!left) state_next = IDLE;
            end
            HOLD: begin
                // Counter reaches zero on the same edge the FSM returns to IDLE.
                cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cap_tgt_reg    <= TGT_NONE;
            cap_cell_reg   <= '1;
            cnt_reg        <= '0;
            left_d_reg     <= 1'b0;
            start_reg      <= 1'b0;
            player_reg     <= 1'b0;
            enemy_reg      <= 1'b0;
            click_cor_reg  <= '1;
            player_cor_reg <= '1;
            enemy_cor_reg  <= '1;
        end else begin
            state_reg      <= state_next;
            cap_tgt_reg    <= cap_tgt_next;
            cap_cell_reg   <= cap_cell_next;
            cnt_reg        <= cnt_next;
            left_d_reg     <= left;
            start_reg      <= start_next;
            player_reg     <= player_next;
            enemy_reg      <= enemy_next;
            click_cor_reg  <= click_cor_next;
            player_cor_reg <= board_cell[0];
            enemy_cor_reg  <= board_cell[1];
        end
    end

    assign player_cor   = player_cor_reg;
    assign enemy_cor    = enemy_cor_reg;
    assign start_click  = start_reg;
    assign player_click = player_reg;
    assign enemy_click  = enemy_reg;
    assign click_cor    = click_cor_reg;
    assign busy         = (state_reg != IDLE);

endmodule
